// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD host sequencer: command encodings,
// image geometry and the issue FSM state type.
package lcd_pkg;

  localparam int PIX_W  = 8;
  localparam int NPIX   = 64;
  localparam int ADDR_W = 6;
  localparam int CMD_W  = 3;
  localparam int CNT_W  = 7;
  localparam int SUM_W  = 14;

  typedef enum logic [CMD_W-1:0] {
    CMD_WRITE = 3'b000,
    CMD_UP    = 3'b001,
    CMD_DOWN  = 3'b010,
    CMD_LEFT  = 3'b011,
    CMD_RIGHT = 3'b100,
    CMD_AVG   = 3'b101,
    CMD_MIRX  = 3'b110,
    CMD_MIRY  = 3'b111
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GUARD,
    ST_WAITB,
    ST_WAITD,
    ST_FIN
  } state_t;

endpackage

// File: rtl/lcd_host_seq_if.sv
// Host/controller/IRB signal bundle for lcd_host_seq. master is the
// sequencer side, slave is the host + controller environment.
interface lcd_host_seq_if;
  import lcd_pkg::*;

  logic [CMD_W-1:0]  cmd_in;
  logic              cmd_push;
  logic              fifo_full;
  logic              busy;
  logic              done;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_valid;
  logic              IRB_RW;
  logic [ADDR_W-1:0] IRB_A;
  logic [PIX_W-1:0]  IRB_D;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [CNT_W-1:0]  wr_count;
  logic [SUM_W-1:0]  checksum;
  logic              frame_full;
  logic              dup_err;
  logic              seq_done;

  modport master (
    input  cmd_in, cmd_push, busy, done, IRB_RW, IRB_A, IRB_D, rd_addr,
    output fifo_full, cmd, cmd_valid, rd_data, wr_count, checksum,
           frame_full, dup_err, seq_done
  );

  modport slave (
    output cmd_in, cmd_push, busy, done, IRB_RW, IRB_A, IRB_D, rd_addr,
    input  fifo_full, cmd, cmd_valid, rd_data, wr_count, checksum,
           frame_full, dup_err, seq_done
  );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module lcd_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr_reg;
  logic [PW:0]  rd_ptr_reg;
  logic [W-1:0] mem [DEPTH];
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                   (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  // Both qualifiers use registered state, so a pop never frees room for a same-cycle push.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg[PW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[PW-1:0]] <= din;
  end

endmodule

// File: rtl/lcd_host_seq.sv
// Host sequencer: issues queued commands to the LCD controller and
// captures the controller's IRB pixel writes into an image store.
module lcd_host_seq
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input logic           clk,
  input logic           reset,
  lcd_host_seq_if.master bus
);

  state_t           state_reg;
  logic [CMD_W-1:0] cmd_reg;
  logic             cmd_valid_reg;
  logic             seq_done_reg;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_head;
  logic             fifo_pop;

  assign fifo_pop = (state_reg == ST_ISSUE);

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.cmd_push),
    .pop   (fifo_pop),
    .din   (bus.cmd_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cmd_reg       <= '0;
      cmd_valid_reg <= 1'b0;
      seq_done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty && !bus.busy) begin
            state_reg     <= ST_ISSUE;
            cmd_reg       <= fifo_head;
            cmd_valid_reg <= 1'b1;
          end
        end
        ST_ISSUE: begin
          cmd_valid_reg <= 1'b0;
          state_reg     <= (cmd_reg == CMD_WRITE) ? ST_WAITD : ST_GUARD;
        end
        // busy is only trustworthy one cycle after the controller saw cmd_valid.
        ST_GUARD: state_reg <= ST_WAITB;
        ST_WAITB: if (!bus.busy) state_reg <= ST_IDLE;
        ST_WAITD: begin
          if (bus.done) begin
            seq_done_reg <= 1'b1;
            state_reg    <= ST_FIN;
          end
        end
        ST_FIN:   state_reg <= ST_FIN;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  // IRB capture runs regardless of FSM state.
  logic              wr_en;
  logic              first_write;
  logic              valid_reg [NPIX];
  logic [PIX_W-1:0]  img_mem [NPIX];
  logic [CNT_W-1:0]  wr_count_reg, wr_count_next;
  logic [SUM_W-1:0]  checksum_reg, checksum_next;
  logic              dup_err_reg, dup_err_next;
  logic              frame_full_reg;

  assign wr_en       = !bus.IRB_RW;
  assign first_write = !valid_reg[bus.IRB_A];

  generate
    for (genvar gi = 0; gi < NPIX; gi++) begin : g_valid
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          valid_reg[gi] <= 1'b0;
        else if (wr_en && bus.IRB_A == ADDR_W'(gi))
          valid_reg[gi] <= 1'b1;
      end
    end
  endgenerate

  always_comb begin
    wr_count_next = wr_count_reg;
    checksum_next = checksum_reg;
    dup_err_next  = dup_err_reg;
    if (wr_en) begin
      if (first_write) begin
        wr_count_next = wr_count_reg + 1'b1;
        checksum_next = checksum_reg + SUM_W'(bus.IRB_D);
      end else begin
        dup_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count_reg   <= '0;
      checksum_reg   <= '0;
      dup_err_reg    <= 1'b0;
      frame_full_reg <= 1'b0;
    end else begin
      wr_count_reg   <= wr_count_next;
      checksum_reg   <= checksum_next;
      dup_err_reg    <= dup_err_next;
      frame_full_reg <= (wr_count_next == CNT_W'(NPIX));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) img_mem[bus.IRB_A] <= bus.IRB_D;
  end

  assign bus.rd_data    = img_mem[bus.rd_addr];
  assign bus.fifo_full  = fifo_full;
  assign bus.cmd        = cmd_reg;
  assign bus.cmd_valid  = cmd_valid_reg;
  assign bus.seq_done   = seq_done_reg;
  assign bus.wr_count   = wr_count_reg;
  assign bus.checksum   = checksum_reg;
  assign bus.frame_full = frame_full_reg;
  assign bus.dup_err    = dup_err_reg;

endmodule

// File: tb/tb_lcd_host_seq.sv
// Scoreboard bench for lcd_host_seq: expected issues are queued at push
// time and checked by an independent cmd_valid monitor.
module tb_lcd_host_seq;
  import lcd_pkg::*;

  logic clk;
  logic reset;
  lcd_host_seq_if bus ();

  lcd_host_seq #(.FIFO_DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;
  int cyc = 0;
  int last_issue = -100;
  logic [2:0] sb_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: every issue strobe is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        last_issue = -100;
      end else if (bus.cmd_valid) begin
        issue_cnt++;
        chk("issue_not_busy", int'(bus.busy), 0);
        chk("issue_spacing_ok", int'((cyc - last_issue) >= 3), 1);
        last_issue = cyc;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got cmd %0d expected no issue", bus.cmd);
        end else begin
          chk("issue_cmd", int'(bus.cmd), int'(sb_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] c, input bit expect_issue);
    bus.cmd_in   = c;
    bus.cmd_push = 1'b1;
    if (expect_issue) sb_q.push_back(c);
    tick();
    bus.cmd_push = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb_q.size() != 0; i++) tick();
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic irb_write(input logic [5:0] a, input logic [7:0] d);
    bus.IRB_RW = 1'b0;
    bus.IRB_A  = a;
    bus.IRB_D  = d;
    tick();
    bus.IRB_RW = 1'b1;
  endtask

  task automatic done_pulse();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  initial begin
    logic [2:0] seq [17];
    reset        = 1'b1;
    bus.cmd_in   = '0;
    bus.cmd_push = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.IRB_RW   = 1'b1;
    bus.IRB_A    = '0;
    bus.IRB_D    = '0;
    bus.rd_addr  = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_cmd", int'(bus.cmd), 0);
    chk("rst_cmd_valid", int'(bus.cmd_valid), 0);
    chk("rst_fifo_full", int'(bus.fifo_full), 0);
    chk("rst_wr_count", int'(bus.wr_count), 0);
    chk("rst_checksum", int'(bus.checksum), 0);
    chk("rst_frame_full", int'(bus.frame_full), 0);
    chk("rst_dup_err", int'(bus.dup_err), 0);
    chk("rst_seq_done", int'(bus.seq_done), 0);
    reset = 1'b0;

    // Script held off by busy for 70 cycles, then issued in order
    push_cmd(3'b001, 1'b1);
    push_cmd(3'b100, 1'b1);
    push_cmd(3'b000, 1'b1);
    repeat (67) tick();
    chk("no_issue_while_busy", issue_cnt, 0);
    bus.busy = 1'b0;
    wait_drain(100);
    chk("script_issues", issue_cnt, 3);
    tick();
    chk("seq_done_before_done", int'(bus.seq_done), 0);
    done_pulse();
    chk("seq_done_after_done", int'(bus.seq_done), 1);

    // 17 pushes into a 16-deep FIFO while busy
    pulse_reset();
    bus.busy = 1'b1;
    for (int i = 0; i < 17; i++) seq[i] = 3'(1 + (i % 7));
    for (int i = 0; i < 15; i++) push_cmd(seq[i], 1'b1);
    chk("fifo_not_full_15", int'(bus.fifo_full), 0);
    push_cmd(seq[15], 1'b1);
    chk("fifo_full_16", int'(bus.fifo_full), 1);
    push_cmd(seq[16], 1'b0);
    chk("fifo_full_17", int'(bus.fifo_full), 1);
    issue_cnt = 0;
    bus.busy = 1'b0;
    wait_drain(200);
    repeat (10) tick();
    chk("burst_issues", issue_cnt, 16);
    chk("burst_end_idle", int'(dut.state_reg), int'(ST_IDLE));
    chk("burst_fifo_not_full", int'(bus.fifo_full), 0);

    // Full frame of IRB writes, data = address
    for (int a = 0; a < 63; a++) irb_write(6'(a), 8'(a));
    chk("wr_count_63", int'(bus.wr_count), 63);
    chk("frame_full_63", int'(bus.frame_full), 0);
    irb_write(6'd63, 8'd63);
    chk("wr_count_64", int'(bus.wr_count), 64);
    chk("frame_full_64", int'(bus.frame_full), 1);
    chk("checksum_frame", int'(bus.checksum), 2016);
    chk("dup_err_clean", int'(bus.dup_err), 0);
    bus.rd_addr = 6'd37;
    #1;
    chk("rd_data_37", int'(bus.rd_data), 37);

    // Duplicate write to address 0, read of same address sees old data
    bus.rd_addr = 6'd0;
    bus.IRB_RW  = 1'b0;
    bus.IRB_A   = 6'd0;
    bus.IRB_D   = 8'hFF;
    @(negedge clk);
    chk("rd_old_same_cycle", int'(bus.rd_data), 0);
    tick();
    bus.IRB_RW = 1'b1;
    chk("dup_err_set", int'(bus.dup_err), 1);
    chk("rd_data_0_new", int'(bus.rd_data), 255);
    chk("checksum_after_dup", int'(bus.checksum), 2016);
    chk("wr_count_after_dup", int'(bus.wr_count), 64);

    // Reset while waiting on busy with two commands still queued
    bus.busy = 1'b1;
    push_cmd(3'b001, 1'b1);
    push_cmd(3'b010, 1'b0);
    push_cmd(3'b011, 1'b0);
    bus.busy = 1'b0;
    tick();
    tick();
    bus.busy = 1'b1;
    repeat (3) tick();
    chk("in_waitb", int'(dut.state_reg), int'(ST_WAITB));
    reset = 1'b1;
    #1;
    chk("abort_cmd_valid", int'(bus.cmd_valid), 0);
    chk("abort_fifo_empty", int'(dut.fifo_empty), 1);
    chk("abort_wr_count", int'(bus.wr_count), 0);
    chk("abort_dup_err", int'(bus.dup_err), 0);
    chk("abort_frame_full", int'(bus.frame_full), 0);
    tick();
    reset = 1'b0;
    bus.busy = 1'b0;
    issue_cnt = 0;
    repeat (20) tick();
    chk("no_issue_after_abort", issue_cnt, 0);
    push_cmd(3'b101, 1'b1);
    wait_drain(20);
    chk("issue_after_abort", issue_cnt, 1);

    // Write then Up: FIN swallows the rest of the script
    pulse_reset();
    issue_cnt = 0;
    push_cmd(3'b000, 1'b1);
    push_cmd(3'b001, 1'b0);
    wait_drain(20);
    repeat (3) tick();
    done_pulse();
    chk("fin_seq_done", int'(bus.seq_done), 1);
    repeat (50) tick();
    chk("fin_issues", issue_cnt, 1);
    chk("fin_state", int'(dut.state_reg), int'(ST_FIN));
    chk("fin_fifo_holds", int'(dut.fifo_empty), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lcd_host_seq.md
Name: lcd_host_seq

Overview:
- Host-side counterpart to the LCD controller. It buffers a script of 3-bit commands and issues them over the cmd/cmd_valid/busy handshake.
- It also acts as the IRB responder: it captures every pixel the controller writes (IRB_RW/IRB_A/IRB_D) into a 64x8 image store and reports a checksum and completion.
- It sits between the test/host logic and the controller, and closes the loop on the controller's output image.

Parameters:
- FIFO_DEPTH, 16, command FIFO entries (power of 2, min 2).
- PIX_W, 8, pixel width.
- NPIX, 64, image size (8x8); address width 6.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_in  in  3  command to enqueue.
- cmd_push  in  1  enqueue strobe.
- fifo_full  out  1  FIFO full; a push while high is dropped.
- busy  in  1  controller busy.
- done  in  1  controller done.
- cmd  out  3  command to controller.
- cmd_valid  out  1  one-cycle issue strobe.
- IRB_RW  in  1  0 = write strobe from controller.
- IRB_A  in  6  write address.
- IRB_D  in  8  write data.
- rd_addr  in  6  image store read address.
- rd_data  out  8  combinational read of the image store.
- wr_count  out  7  distinct addresses written.
- checksum  out  14  sum of first-write data per address.
- frame_full  out  1  all NPIX addresses written.
- dup_err  out  1  sticky: an address was written twice.
- seq_done  out  1  Write command completed (done seen).

Behaviour:
- Reset values:
  - All outputs 0 (cmd=000, cmd_valid=0, fifo_full=0, counters 0).
  - FIFO emptied; valid mask cleared; FSM in IDLE.
  - Image store data is not reset. rd_data of unwritten addresses is don't-care.
- Reset mid-operation aborts any issue in flight immediately.
- FIFO:
  - Push accepted when cmd_push=1 and fifo_full=0, evaluated on registered state.
  - A pop in the same cycle does not make room for a push.
  - Pop occurs only in the ISSUE state.
  - Pointers wrap modulo FIFO_DEPTH. An extra occupancy bit distinguishes full from empty.
- Issue FSM states are IDLE, ISSUE, GUARD, WAITB, WAITD, FIN:
  - IDLE: if FIFO not empty and busy=0 -> ISSUE.
  - ISSUE (1 cycle):
    - Drive cmd=head and cmd_valid=1, then pop.
    - If cmd=000 (Write) -> WAITD, else -> GUARD.
  - GUARD (1 cycle):
    - cmd_valid=0 and busy is ignored, because the controller samples cmd_valid and raises busy on the same edge.
    - Then -> WAITB.
  - WAITB: when busy=0 -> IDLE. Back-to-back issue spacing is therefore at least 3 cycles.
  - WAITD: wait for done=1, then set seq_done=1 (sticky) -> FIN.
  - FIN: terminal. No further issue; queued commands stay in the FIFO. Only reset exits.
- busy is high after reset until the controller finishes its IROM load. IDLE never issues while busy=1.
- cmd holds its last value when cmd_valid=0.
- IRB capture (independent of FSM, including in FIN), on each clock edge with IRB_RW=0:
  - mem[IRB_A] <= IRB_D.
  - If valid[IRB_A]=0: set it, wr_count += 1, checksum += IRB_D.
  - Else: set dup_err (sticky). checksum and wr_count are unchanged and the data is overwritten.
- frame_full is registered and equals (wr_count == NPIX).
- Widths:
  - checksum is a 14-bit unsigned accumulator. The maximum is 64*255 = 16320, so it never wraps.
  - wr_count saturates naturally at 64.
- Simultaneous events:
  - A push in the same cycle as an issue pop is legal when not full.
  - An IRB write in the same cycle as a rd_addr read of the same address returns the old data (read is before the edge).

Decomposition:
- Shared package lcd_pkg:
  - Command encodings CMD_WRITE=000, CMD_UP=001, CMD_DOWN=010, CMD_LEFT=011, CMD_RIGHT=100, CMD_AVG=101, CMD_MIRX=110, CMD_MIRY=111.
  - NPIX, PIX_W, ADDR_W=6.
  - FSM state enum.
- One sub-module, lcd_cmd_fifo: a synchronous FIFO with push/pop/full/empty/head. The issue FSM and IRB capture stay in the top level.

Test Plan:
- Reset, busy held 1 for 70 cycles, then 0, with FIFO {001,100,000} -> no cmd_valid while busy=1.
  - Then three single-cycle cmd_valid pulses with cmd=001, 100, 000 in order, each ≥3 cycles apart.
  - seq_done=1 one cycle after done=1.
- Push 17 commands into FIFO_DEPTH=16 with busy=1 -> fifo_full=1 after 16; the 17th is dropped.
  - After release, exactly 16 issues occur (no Write among them), and FSM ends in IDLE.
- IRB writes addr 0..63 with data=addr, IRB_RW=0 -> wr_count=64, frame_full=1, checksum=2016, dup_err=0.
  - rd_addr=37 gives rd_data=37.
- After a full frame, one more write addr 0 data 0xFF -> dup_err=1, rd_data(0)=0xFF, checksum stays 2016, wr_count stays 64.
- Assert reset during WAITB with 2 commands queued -> cmd_valid=0, FIFO empty, wr_count=0, dup_err=0.
  - After reset release, no issue occurs until new pushes arrive and busy=0.
- Queue {000,001} -> only 000 is issued; after done, FIN holds, and 001 is never issued across 50 cycles of busy=0.
